// File: rtl/spi_slave_trx.sv
// SPI slave (mode 0, MSB first), every SPI pin oversampled in the clk domain.
// Define SPI_SLAVE_CS_EN to enable chip-select framing and the MISO output enable.
module spi_slave_trx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_sck_i,
   input  logic       spi_mosi_i,
   input  logic       spi_cs_n_i,
   output logic       spi_miso_o,
   output logic       spi_miso_oe_o,
   output logic [7:0] rdata,
   output logic       rvalid,
   input  logic       rready,
   output logic       overrun,
   input  logic [7:0] wdata,
   input  logic       wvalid,
   output logic       wready
);

   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic       sck_hist_q, sck_hist_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] rx_shift_q, rx_shift_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic [7:0] rdata_q, rdata_d;
   logic [7:0] hold_q, hold_d;
   logic       rvalid_q, rvalid_d;
   logic       overrun_q, overrun_d;
   logic       hold_full_q, hold_full_d;

   logic sck_s, mosi_s, active_s, cs_fall_s;
   logic sck_rise_s, sck_fall_s, complete_s, load_s, preload_s;

   assign sck_s  = sck_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

`ifdef SPI_SLAVE_CS_EN
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic cs_hist_q, cs_hist_d;
   logic oe_q, oe_d;
   logic cs_s;

   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign active_s  = ~cs_s;
   assign cs_fall_s = ~cs_s & cs_hist_q;

   // chip-select synchronizer, history and output-enable next state
   always_comb begin
      cs_sync_d = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
      cs_hist_d = cs_s;
      oe_d      = ~cs_s;
   end

   // chip-select registers; reset to deselected so no false falling edge appears
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_sync_q <= {SYNC_STAGES{1'b1}};
         cs_hist_q <= 1'b1;
         oe_q      <= 1'b0;
      end else begin
         cs_sync_q <= cs_sync_d;
         cs_hist_q <= cs_hist_d;
         oe_q      <= oe_d;
      end
   end

   assign spi_miso_oe_o = oe_q;
`else
   logic unused_cs_s;

   assign unused_cs_s   = spi_cs_n_i;
   assign active_s      = 1'b1;
   assign cs_fall_s     = 1'b0;
   assign spi_miso_oe_o = 1'b1;
`endif

   // edge detection, shift/count datapath, holding register and user handshake
   always_comb begin
      sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      sck_hist_d  = sck_s;
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      rdata_d     = rdata_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      rvalid_d    = rvalid_q;
      overrun_d   = 1'b0;

      sck_rise_s = active_s & sck_s & ~sck_hist_q;
      sck_fall_s = active_s & ~sck_s & sck_hist_q;
      complete_s = sck_rise_s & (bit_cnt_q == 3'd7);
      load_s     = complete_s | cs_fall_s;
      // a cs falling edge does its own load, so idle preload waits for it
      preload_s  = hold_full_q & active_s & ~cs_fall_s & ~sck_rise_s & (bit_cnt_q == 3'd0);

      if (!active_s) begin
         bit_cnt_d  = 3'd0;
         rx_shift_d = 8'h00;
      end else if (sck_rise_s) begin
         bit_cnt_d  = bit_cnt_q + 3'd1;
         rx_shift_d = {rx_shift_q[6:0], mosi_s};
      end else begin
         bit_cnt_d  = bit_cnt_q;
         rx_shift_d = rx_shift_q;
      end

      // the fall right after a load keeps bit 7 on the pin for the next sample
      if (load_s) begin
         tx_shift_d = hold_full_q ? hold_q : 8'h00;
      end else if (preload_s) begin
         tx_shift_d = hold_q;
      end else if (sck_fall_s && (bit_cnt_q != 3'd0)) begin
         tx_shift_d = {tx_shift_q[6:0], 1'b0};
      end else begin
         tx_shift_d = tx_shift_q;
      end

      if ((load_s || preload_s) && hold_full_q) begin
         hold_full_d = 1'b0;
      end else if (wvalid && !hold_full_q) begin
         hold_full_d = 1'b1;
         hold_d      = wdata;
      end else begin
         hold_full_d = hold_full_q;
      end

      if (complete_s) begin
         rdata_d   = {rx_shift_q[6:0], mosi_s};
         rvalid_d  = 1'b1;
         overrun_d = rvalid_q & ~rready;
      end else if (rvalid_q && rready) begin
         rvalid_d = 1'b0;
      end else begin
         rvalid_d = rvalid_q;
      end
   end

   // state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_sync_q  <= {SYNC_STAGES{1'b0}};
         mosi_sync_q <= {SYNC_STAGES{1'b0}};
         sck_hist_q  <= 1'b0;
         bit_cnt_q   <= 3'd0;
         rx_shift_q  <= 8'h00;
         tx_shift_q  <= 8'h00;
         rdata_q     <= 8'h00;
         hold_q      <= 8'h00;
         hold_full_q <= 1'b0;
         rvalid_q    <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         sck_sync_q  <= sck_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sck_hist_q  <= sck_hist_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         rdata_q     <= rdata_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         rvalid_q    <= rvalid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign spi_miso_o = tx_shift_q[7];
   assign rdata      = rdata_q;
   assign rvalid     = rvalid_q;
   assign overrun    = overrun_q;
   assign wready     = ~hold_full_q;

endmodule

// File: tb/tb_spi_slave_trx.sv
// Directed bench for spi_slave_trx: a bit-banged SPI master plus a pulse monitor.
module tb_spi_slave_trx;

   localparam int HALF = 6;

   logic       clk = 1'b0;
   logic       rst;
   logic       spi_sck_i, spi_mosi_i, spi_cs_n_i;
   logic       spi_miso_o, spi_miso_oe_o;
   logic [7:0] rdata;
   logic       rvalid, rready, overrun;
   logic [7:0] wdata;
   logic       wvalid, wready;

   int checks   = 0;
   int failures = 0;
   int rv_cnt   = 0;
   int ov_cnt   = 0;
   logic [7:0] last_rdata = 8'h00;

   spi_slave_trx #(.SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst),
      .spi_sck_i(spi_sck_i), .spi_mosi_i(spi_mosi_i), .spi_cs_n_i(spi_cs_n_i),
      .spi_miso_o(spi_miso_o), .spi_miso_oe_o(spi_miso_oe_o),
      .rdata(rdata), .rvalid(rvalid), .rready(rready), .overrun(overrun),
      .wdata(wdata), .wvalid(wvalid), .wready(wready)
   );

   always #5 clk = ~clk;

   // count valid cycles and overrun pulses, remember the last delivered byte
   always @(negedge clk) begin
      if (rvalid) begin
         rv_cnt     <= rv_cnt + 1;
         last_rdata <= rdata;
      end
      if (overrun) ov_cnt <= ov_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // master: drive MOSI while SCK low, sample MISO at the rising edge
   task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi_i = tx[7-i];
         tick(HALF);
         spi_sck_i = 1'b1;
         rx = {rx[6:0], spi_miso_o};
         tick(HALF);
         spi_sck_i = 1'b0;
      end
      tick(HALF);
   endtask

   task automatic write_byte(input logic [7:0] d);
      wdata  = d;
      wvalid = 1'b1;
      tick(1);
      wvalid = 1'b0;
   endtask

   initial begin
      logic [7:0] rx1, rx2;
      int rv_base, ov_base;
      rst = 1'b1; spi_sck_i = 1'b0; spi_mosi_i = 1'b0; rready = 1'b1;
      wdata = 8'h00; wvalid = 1'b0;
`ifdef SPI_SLAVE_CS_EN
      spi_cs_n_i = 1'b1;
`else
      spi_cs_n_i = 1'b0;
`endif
      tick(3);
      @(negedge clk);
      check_eq("rst_miso", {31'd0, spi_miso_o}, 32'd0);
`ifdef SPI_SLAVE_CS_EN
      check_eq("rst_oe", {31'd0, spi_miso_oe_o}, 32'd0);
`else
      check_eq("rst_oe", {31'd0, spi_miso_oe_o}, 32'd1);
`endif
      check_eq("rst_rdata", {24'd0, rdata}, 32'h00);
      check_eq("rst_rvalid", {31'd0, rvalid}, 32'd0);
      check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
      check_eq("rst_wready", {31'd0, wready}, 32'd1);
      tick(1);
      rst = 1'b0;
      tick(2);
`ifdef SPI_SLAVE_CS_EN
      spi_cs_n_i = 1'b0;
      tick(5);
      check_eq("cs_low_oe", {31'd0, spi_miso_oe_o}, 32'd1);
`endif

      // single byte, consumer always ready
      rv_base = rv_cnt; ov_base = ov_cnt;
      spi_bits(8'hA5, 8, rx1);
      tick(4);
      check_eq("a5_pulses", rv_cnt - rv_base, 32'd1);
      check_eq("a5_rdata", {24'd0, last_rdata}, 32'hA5);
      check_eq("a5_overrun", ov_cnt - ov_base, 32'd0);
      check_eq("a5_rvalid_clr", {31'd0, rvalid}, 32'd0);
      check_eq("a5_miso", {24'd0, rx1}, 32'h00);

      // idle write is preloaded and returned in the next frame
      write_byte(8'h3C);
      @(negedge clk);
      check_eq("3c_wready_busy", {31'd0, wready}, 32'd0);
      @(negedge clk);
      check_eq("3c_wready_back", {31'd0, wready}, 32'd1);
      tick(2);
      rv_base = rv_cnt;
      spi_bits(8'h00, 8, rx1);
      tick(4);
      check_eq("3c_miso", {24'd0, rx1}, 32'h3C);
      check_eq("3c_rdata", {24'd0, last_rdata}, 32'h00);
      check_eq("3c_pulses", rv_cnt - rv_base, 32'd1);

      // two bytes without consuming: overrun on the second, MISO stays zero
      rready = 1'b0;
      ov_base = ov_cnt;
      spi_bits(8'h11, 8, rx1);
      spi_bits(8'h22, 8, rx2);
      tick(4);
      check_eq("ovr_rdata", {24'd0, rdata}, 32'h22);
      check_eq("ovr_rvalid", {31'd0, rvalid}, 32'd1);
      check_eq("ovr_pulses", ov_cnt - ov_base, 32'd1);
      check_eq("nowr_miso1", {24'd0, rx1}, 32'h00);
      check_eq("nowr_miso2", {24'd0, rx2}, 32'h00);
      rready = 1'b1;
      tick(1);
      @(negedge clk);
      check_eq("ovr_consumed", {31'd0, rvalid}, 32'd0);

      // reset mid-byte with a pending write
      spi_bits(8'hF0, 4, rx1);
      write_byte(8'h77);
      @(negedge clk);
      check_eq("mid_wready", {31'd0, wready}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check_eq("mrst_wready", {31'd0, wready}, 32'd1);
      check_eq("mrst_rdata", {24'd0, rdata}, 32'h00);
      check_eq("mrst_rvalid", {31'd0, rvalid}, 32'd0);
      check_eq("mrst_miso", {31'd0, spi_miso_o}, 32'd0);
      check_eq("mrst_overrun", {31'd0, overrun}, 32'd0);
      tick(1);
      rst = 1'b0;
      tick(6);
      rv_base = rv_cnt;
      spi_bits(8'h5A, 8, rx1);
      tick(4);
      check_eq("5a_rdata", {24'd0, last_rdata}, 32'h5A);
      check_eq("5a_pulses", rv_cnt - rv_base, 32'd1);
      check_eq("5a_miso_hold_cleared", {24'd0, rx1}, 32'h00);

`ifdef SPI_SLAVE_CS_EN
      // partial byte aborted by deselect is discarded
      rv_base = rv_cnt; ov_base = ov_cnt;
      spi_bits(8'hFF, 5, rx1);
      spi_cs_n_i = 1'b1;
      tick(5);
      check_eq("cs_high_oe", {31'd0, spi_miso_oe_o}, 32'd0);
      spi_cs_n_i = 1'b0;
      tick(5);
      spi_bits(8'hC3, 8, rx1);
      tick(4);
      check_eq("c3_rdata", {24'd0, last_rdata}, 32'hC3);
      check_eq("c3_pulses", rv_cnt - rv_base, 32'd1);
      check_eq("c3_overrun", ov_cnt - ov_base, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_slave_trx.md
# spi_slave_trx

SPI slave endpoint for the on-board byte-wide SPI master: SCK idles low, MSB first, MOSI sampled on SCK rising edge, MISO changed on SCK falling edge. All SPI pins are oversampled in the system `clk` domain, so no logic is clocked by SCK. Received bytes go to the user side over a valid/ready pair. A one-deep holding register supplies the byte returned on MISO in the next frame.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth on `spi_sck_i`, `spi_mosi_i` and `spi_cs_n_i`. Legal values are 2 or 3.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `spi_sck_i`  in  1  SPI clock from the master.
- `spi_mosi_i`  in  1  master-out data.
- `spi_cs_n_i`  in  1  chip select, active-low. Ignored unless `SPI_SLAVE_CS_EN` is defined.
- `spi_miso_o`  out  1  slave-out data. Equals `tx_shift[7]`.
- `spi_miso_oe_o`  out  1  MISO output enable.
- `rdata`  out  8  last received byte.
- `rvalid`  out  1  `rdata` holds an unconsumed byte.
- `rready`  in  1  user consumes `rdata`.
- `overrun`  out  1  one-cycle pulse when a byte completes while `rvalid` is still high.
- `wdata`  in  8  byte to send in the next frame.
- `wvalid`  in  1  `wdata` is offered.
- `wready`  out  1  holding register is empty.

## Operation
- Synchronizer and edge detection:
  - Each input passes through `SYNC_STAGES` flops, then one history flop.
  - `sck_rise` = synced high AND history low. `sck_fall` is the inverse condition.
- Bit counter `bit_cnt` is 3 bits:
  - Increments on every `sck_rise`, wrapping 7 → 0.
  - On `sck_rise`, `rx_shift <= {rx_shift[6:0], mosi_synced}`.
- Byte completion is the `sck_rise` that wraps `bit_cnt` to 0. On that edge:
  - `rdata <= {rx_shift[6:0], mosi_synced}` and `rvalid <= 1`.
  - If `rvalid` was already 1 and `rready` was 0 in that cycle, `rdata` is overwritten and `overrun` pulses.
  - `tx_shift` loads from the holding register if it is full, then the holding register is cleared. If the holding register is empty, `tx_shift` loads `8'h00`.
- On `sck_fall` with `bit_cnt != 0`: `tx_shift <= {tx_shift[6:0], 1'b0}`. A falling edge with `bit_cnt == 0` does not shift, so bit 7 of the newly loaded byte is held for the master's next sample.
- `rvalid` clears on `rvalid && rready`. A completion in the same cycle wins, so `rvalid` stays 1 with the new data and no `overrun`.
- Holding register:
  - `wready = ~hold_full`.
  - The register captures `wdata` on `wvalid && wready`.
  - Idle preload: when `hold_full` is set and the block is idle (`bit_cnt == 0`, no transfer in progress), `tx_shift` takes the held byte on the next cycle and the register is cleared. The first frame therefore returns that byte.
  - A write accepted in the same cycle as a completion load is held for the following frame.

## Timing
- Reset values: `spi_miso_o=0`, `spi_miso_oe_o=0` (1 without the macro), `rdata=8'h00`, `rvalid=0`, `overrun=0`, `wready=1`, `bit_cnt=0`, `tx_shift=8'h00`.
- Latency: `rvalid` rises `SYNC_STAGES+1` clk edges after the 8th SCK rising edge at the pin.
- `spi_miso_o` changes `SYNC_STAGES+1` clk edges after an SCK falling edge at the pin.
- SCK high and low phases must each be at least `SYNC_STAGES+2` clk periods. The master with `CLK_DIV >= 8` satisfies this at `SYNC_STAGES=2`.
- Reset asserted mid-byte returns every register to its reset value immediately. The partial byte is lost and the holding register is emptied.

## Configuration
- `SPI_SLAVE_CS_EN` defined:
  - `cs_n` is synchronized.
  - While `cs_n` is high: `bit_cnt=0`, `rx_shift` is cleared, SCK edges are ignored, and `spi_miso_oe_o=0`.
  - On the synced falling edge of `cs_n`, `tx_shift` loads from the holding register, or `8'h00` if it is empty.
  - A `cs_n` rising edge mid-byte discards the partial byte. No `rvalid` and no `overrun` are produced.
- `SPI_SLAVE_CS_EN` undefined:
  - `spi_cs_n_i` is unused and `spi_miso_oe_o` is tied to 1.
  - Framing comes from `bit_cnt` only. Resynchronization happens through `rst` only.

## Test plan
- Master sends `8'hA5`, `rready` held 1 → exactly one `rvalid` pulse with `rdata=8'hA5`. `overrun` stays 0.
- `wdata=8'h3C` written while idle, then master sends `8'h00` → master receives `8'h3C`, and `wready` returns to 1 after the preload.
- Master sends `8'h11` then `8'h22` with `rready=0` → `rdata=8'h22`, one `overrun` pulse on the second byte, `rvalid` still 1.
- No write pending, master sends two bytes → the master reads `8'h00` for both.
- `SPI_SLAVE_CS_EN` defined: `cs_n` raised after 5 bits, then a full byte `8'hC3` is sent → only `8'hC3` is reported and `spi_miso_oe_o` is 0 while `cs_n` is high.
- `rst` pulsed after 4 bits, then a full byte `8'h5A` is sent → all outputs return to their reset values and the next `rdata` is `8'h5A`.
